// File: rtl/fpaddsub_result_buffer.sv
// Output stage of the FP add/sub datapath: a 2-entry valid/ready result buffer
// with sticky exception flags, a saturating exception counter and a masked irq.
module fpaddsub_result_buffer #(
  parameter int WIDTH = 32,
  parameter int FLAGW = 5,
  parameter int CNTW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_p,
  input  logic [FLAGW-1:0] in_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_p,
  output logic [FLAGW-1:0] out_flags,
  input  logic [FLAGW-1:0] flag_mask,
  input  logic             clr_sticky,
  output logic [FLAGW-1:0] sticky_flags,
  output logic [CNTW-1:0]  exc_count,
  output logic             irq
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t state, state_nxt;

  logic             push, pop, exc;
  logic [WIDTH-1:0] head_p, tail_p;
  logic [FLAGW-1:0] head_f, tail_f;

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign exc       = |in_flags[FLAGW-1:1];

  assign out_p     = head_p;
  assign out_flags = head_f;
  assign irq       = |(sticky_flags & flag_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = FULL;
        else if (pop && !push) state_nxt = EMPTY;
      end
      FULL:  if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Head is what downstream sees; tail only holds the second entry while FULL.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_p <= '0;
      head_f <= '0;
      tail_p <= '0;
      tail_f <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            head_p <= in_p;
            head_f <= in_flags;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_p <= in_p;
            head_f <= in_flags;
          end else if (push) begin
            tail_p <= in_p;
            tail_f <= in_flags;
          end
        end
        FULL: begin
          if (pop) begin
            head_p <= tail_p;
            head_f <= tail_f;
          end
        end
        default: ;
      endcase
    end
  end

  // A clear coinciding with a push keeps that push's contribution.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_flags <= '0;
      exc_count    <= '0;
    end else begin
      if (clr_sticky && push) sticky_flags <= in_flags;
      else if (clr_sticky)    sticky_flags <= '0;
      else if (push)          sticky_flags <= sticky_flags | in_flags;

      if (clr_sticky && push && exc)
        exc_count <= CNTW'(1);
      else if (clr_sticky)
        exc_count <= '0;
      else if (push && exc && (exc_count != {CNTW{1'b1}}))
        exc_count <= exc_count + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_fpaddsub_result_buffer.sv
// Scoreboard bench for fpaddsub_result_buffer: stimulus queues expected words,
// a monitor compares them as the buffer hands them downstream.
module tb_fpaddsub_result_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, clr_sticky, irq;
  logic [31:0] in_p, out_p;
  logic [4:0]  in_flags, out_flags, flag_mask, sticky_flags;
  logic [7:0]  exc_count;

  int checks = 0;
  int errors = 0;
  logic [36:0] expq[$];

  fpaddsub_result_buffer #(.WIDTH(32), .FLAGW(5), .CNTW(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_p(in_p), .in_flags(in_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p), .out_flags(out_flags),
    .flag_mask(flag_mask), .clr_sticky(clr_sticky),
    .sticky_flags(sticky_flags), .exc_count(exc_count), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one word for one cycle; in_ready is stable between negedge and posedge.
  task automatic applyStimulus(input logic [31:0] p, input logic [4:0] f, output bit accepted);
    in_valid = 1'b1;
    in_p     = p;
    in_flags = f;
    @(negedge clk);
    accepted = in_ready;
    if (accepted) expq.push_back({f, p});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expq.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    checkOutput("drain_empty", expq.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [36:0] e;
      if (expq.size() == 0) begin
        checkOutput("unexpected_pop", 1, 0);
      end else begin
        e = expq.pop_front();
        checkOutput("out_p", out_p, e[31:0]);
        checkOutput("out_flags", {27'd0, out_flags}, {27'd0, e[36:32]});
      end
    end
  end

  initial begin
    bit acc;
    rst = 1'b1; in_valid = 0; in_p = '0; in_flags = '0;
    out_ready = 1'b1; clr_sticky = 0; flag_mask = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    $display("[TB] reset state");
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_sticky", sticky_flags, 0);
    checkOutput("rst_count", exc_count, 0);
    checkOutput("rst_irq", irq, 0);

    $display("[TB] single push");
    applyStimulus(32'h3F800000, 5'b00001, acc);
    checkOutput("single_out_valid", out_valid, 1);
    checkOutput("single_sticky", sticky_flags, 5'b00001);
    checkOutput("single_count", exc_count, 0);
    waitDrain();

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(32'h40000000, 5'b00000, acc);
    checkOutput("bp_in_ready_one", in_ready, 1);
    applyStimulus(32'h40400000, 5'b00000, acc);
    checkOutput("bp_in_ready_full", in_ready, 0);
    checkOutput("bp_out_hold", out_p, 32'h40000000);
    applyStimulus(32'h40800000, 5'b00000, acc);
    checkOutput("bp_third_rejected", acc, 0);
    out_ready = 1'b1;
    tick();
    checkOutput("bp_in_ready_after_pop", in_ready, 1);
    waitDrain();

    $display("[TB] sticky and mask");
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    checkOutput("clr_sticky", sticky_flags, 0);
    checkOutput("clr_count", exc_count, 0);
    applyStimulus(32'h3F000000, 5'b10001, acc);
    applyStimulus(32'h3E800000, 5'b01000, acc);
    checkOutput("sticky_or", sticky_flags, 5'b11001);
    checkOutput("count_two", exc_count, 2);
    flag_mask = 5'b00100;
    #1;
    checkOutput("irq_masked", irq, 0);
    flag_mask = 5'b01000;
    #1;
    checkOutput("irq_enabled", irq, 1);
    waitDrain();

    $display("[TB] clear with push");
    clr_sticky = 1'b1;
    applyStimulus(32'h7FC00000, 5'b00010, acc);
    clr_sticky = 1'b0;
    checkOutput("clrpush_sticky", sticky_flags, 5'b00010);
    checkOutput("clrpush_count", exc_count, 1);
    checkOutput("clrpush_irq", irq, 0);
    waitDrain();

    $display("[TB] saturation");
    clr_sticky = 1'b1;
    tick();
    clr_sticky = 1'b0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(32'h7F800000 + i, 5'b10000, acc);
      if (i == 99) checkOutput("count_100", exc_count, 100);
      if (i == 254) checkOutput("count_255", exc_count, 255);
    end
    checkOutput("count_saturated", exc_count, 255);
    waitDrain();

    $display("[TB] async reset while full");
    out_ready = 1'b0;
    flag_mask = 5'b11111;
    applyStimulus(32'h11111111, 5'b11111, acc);
    applyStimulus(32'h22222222, 5'b11111, acc);
    checkOutput("pre_rst_in_ready", in_ready, 0);
    checkOutput("pre_rst_irq", irq, 1);
    #2;
    rst = 1'b1;
    #1;
    expq.delete();
    checkOutput("arst_out_valid", out_valid, 0);
    checkOutput("arst_in_ready", in_ready, 1);
    checkOutput("arst_sticky", sticky_flags, 0);
    checkOutput("arst_count", exc_count, 0);
    checkOutput("arst_irq", irq, 0);
    checkOutput("arst_out_p", out_p, 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    applyStimulus(32'h12345678, 5'b00100, acc);
    checkOutput("post_rst_count", exc_count, 1);
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpaddsub_result_buffer.md
# fpaddsub_result_buffer

Output stage of the floating-point add/sub datapath, placed directly after the exception stage. It registers each final result word and its 5-bit exception flag vector into a 2-entry valid/ready buffer, so downstream stalls never break the combinational datapath. It also keeps an IEEE-style sticky flag register, a saturating exception counter and a maskable interrupt.

## Interface
- WIDTH, 32, result word width
- FLAGW, 5, flag vector width; bit order {Overflow, Underflow, DivideByZero, Invalid, Inexact}, bit 4 = Overflow
- CNTW, 8, exception counter width

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream result valid
- in_ready  out  1  buffer can accept this cycle
- in_p  in  WIDTH  final result word from exception stage
- in_flags  in  FLAGW  exception flags from exception stage
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- out_p  out  WIDTH  head result word
- out_flags  out  FLAGW  head flag vector
- flag_mask  in  FLAGW  per-flag interrupt enable
- clr_sticky  in  1  clear sticky flags and counter
- sticky_flags  out  FLAGW  OR of flags of all accepted results since last clear
- exc_count  out  CNTW  number of accepted results with any of flags[4:1] set, saturating
- irq  out  1  |(sticky_flags & flag_mask)

## Operation
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Occupancy FSM: EMPTY, ONE, FULL; reset state EMPTY.
  - EMPTY: push -> ONE.
  - ONE: push & !pop -> FULL; pop & !push -> EMPTY; push & pop -> ONE, new entry becomes head next cycle.
  - FULL: pop -> ONE; no push possible.
- in_ready = (state != FULL). Decoded from state register only, with no combinational path from out_ready.
- out_valid = (state != EMPTY). out_p/out_flags are driven from the head entry register. They are held stable while out_valid & !out_ready.
- Strict FIFO order. Entries are never dropped or duplicated.
- Sticky flags, on each clock edge:
  - clr_sticky & push: sticky_flags <= in_flags.
  - clr_sticky only: sticky_flags <= 0.
  - push only: sticky_flags <= sticky_flags | in_flags.
- Exception counter, with exc = |in_flags[4:1] (Inexact alone does not count):
  - clr_sticky & push & exc: exc_count <= 1.
  - clr_sticky (any other case): exc_count <= 0.
  - push & exc: exc_count <= exc_count + 1, saturating at 2^CNTW-1 (no wrap).
- irq is combinational from sticky_flags and flag_mask. A flag_mask change takes effect in the same cycle.
- Reset, asynchronous and may occur mid-transfer:
  - state EMPTY, both entries and out_p/out_flags = 0.
  - sticky_flags = 0, exc_count = 0.
  - out_valid = 0, in_ready = 1, irq = 0.
  - All buffered results are discarded.

## Timing
- Latency: push at edge N -> out_valid = 1 after edge N, i.e. visible in cycle N+1.
- Throughput: 1 result per cycle with out_ready held high. In steady state the FSM stays in ONE.
- Upstream stall: in_ready deasserts in the cycle after the second unpopped push. It reasserts in the cycle after the first pop.
- sticky_flags/exc_count reflect a push one cycle after its accepting edge. irq follows in the same cycle as sticky_flags.
- Flags are sampled only on push. in_flags is ignored while in_valid = 0 or in_ready = 0.

## Test plan
- Reset then single push of in_p=0x3F800000, in_flags=5'b00001, out_ready=1:
  - next cycle out_valid=1, out_p=0x3F800000, out_flags=00001.
  - sticky=00001, exc_count=0.
- Backpressure with out_ready=0:
  - push A=0x40000000 then B=0x40400000 -> in_ready=0 after B; third in_valid is not accepted.
  - raise out_ready -> A then B emerge in order, with in_ready=1 after the first pop.
- Sticky and mask:
  - push flags 10001 then 01000 -> sticky=11001, exc_count=2.
  - flag_mask=00100 -> irq=0; flag_mask=01000 -> irq=1 in the same cycle.
- Clear with simultaneous push of flags 00010 -> next cycle sticky=00010, exc_count=1.
- Saturation with CNTW=8: 300 pushes with flags 10000 -> exc_count=255, no wrap.
- Asynchronous rst asserted mid-cycle while FULL -> immediately out_valid=0, in_ready=1, sticky=0, exc_count=0, irq=0.
